// File: rtl/fetch_sequencer.sv
// Fetch/decode sequencer: reads the instruction at pc_in, holds it in ir for execute, then steps or jumps the PC once.
// Latency: >=1 FETCH cycle + DECODE handshake + 1 ADVANCE cycle per instruction; ir is held until exec_ready.
// Backpressure: stalls in FETCH until mem_ack (or TIMEOUT cycles with FETCH_TIMEOUT_EN defined) and in DECODE until exec_ready.
module fetch_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               resume,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_req,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               zero_flag,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic               exec_ready,
    output logic               pc_load_n,
    output logic               pc_hold,
    output logic [ADDR_W-1:0]  pc_target,
    output logic               halted,
    output logic               fetch_err
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, ADVANCE, HALTED} state_t;

    localparam logic [3:0] OP_HALT = 4'hD;
    localparam logic [3:0] OP_JZ   = 4'hE;
    localparam logic [3:0] OP_JMP  = 4'hF;

    state_t     state;
    logic       jump_q;
    logic       no_step;
    logic [3:0] opcode;

    assign mem_addr  = pc_in;
    assign pc_target = ir[ADDR_W-1:0];
    assign opcode    = ir[INSTR_W-1 -: 4];

    // PC controls are pure decodes of registered state, active only in ADVANCE.
    assign pc_load_n = !((state == ADVANCE) && jump_q);
    assign pc_hold   = !((state == ADVANCE) && !jump_q && !no_step);

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] to_cnt;
    logic             retry_q;
    logic             err_q;

    assign no_step   = retry_q;
    assign fetch_err = err_q;
`else
    assign no_step   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ir       <= '0;
            jump_q   <= 1'b0;
            mem_req  <= 1'b0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            to_cnt   <= '0;
            retry_q  <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FETCH;
                        mem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        to_cnt  <= '0;
`endif
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        ir       <= mem_rdata;
                        state    <= DECODE;
                        mem_req  <= 1'b0;
                        ir_valid <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    end else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Give up on this address; resume refetches it without stepping.
                        state   <= HALTED;
                        mem_req <= 1'b0;
                        halted  <= 1'b1;
                        err_q   <= 1'b1;
                        retry_q <= 1'b1;
                    end else begin
                        to_cnt  <= to_cnt + CNT_W'(1);
`endif
                    end
                end
                DECODE: begin
                    if (exec_ready) begin
                        ir_valid <= 1'b0;
                        case (opcode)
                            OP_HALT: begin
                                state  <= HALTED;
                                halted <= 1'b1;
                            end
                            OP_JMP: begin
                                jump_q <= 1'b1;
                                state  <= ADVANCE;
                            end
                            OP_JZ: begin
                                jump_q <= zero_flag;
                                state  <= ADVANCE;
                            end
                            default: begin
                                jump_q <= 1'b0;
                                state  <= ADVANCE;
                            end
                        endcase
                    end
                end
                ADVANCE: begin
                    state   <= FETCH;
                    mem_req <= 1'b1;
                    jump_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    to_cnt  <= '0;
                    retry_q <= 1'b0;
`endif
                end
                HALTED: begin
                    if (resume) begin
                        state  <= ADVANCE;
                        halted <= 1'b0;
                        jump_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
